// File: rtl/snake_direction_ctrl.sv
// snake_direction_ctrl: debounces the left/right proximity levels into single
// relative turns, queues them, and commits one turn to the heading on each
// apply_turn strobe from the control unit.
// Build option: define SNAKE_DIR_QUEUE2_EN for a 2-entry turn FIFO; the
// default build keeps a single pending-turn slot.
module snake_direction_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clock,
  input  logic       restart_n,
  input  logic       esq,
  input  logic       dir,
  input  logic       clear_dir,
  input  logic       apply_turn,
  output logic [1:0] direction,
  output logic       turn_pending,
  output logic       turn_dropped,
  output logic [1:0] db_estado
);

`ifdef SNAKE_DIR_QUEUE2_EN
  localparam int QDEPTH = 2;
`else
  localparam int QDEPTH = 1;
`endif

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]    Q_FULL   = 2'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    HOLD = 2'd2,
    RELQ = 2'd3
  } state_t;

  // Relative turn on a 2-bit heading: left is +1, right is -1, natural wrap.
  function automatic logic [1:0] turn_heading(input logic [1:0] heading,
                                              input logic       right);
    turn_heading = right ? (heading - 2'd1) : (heading + 2'd1);
  endfunction

  // ---- stage p0/p1: two-flop synchronizer on the comparator levels ----
  logic esq_p0, esq_p1;
  logic dir_p0, dir_p1;

  // Bring the asynchronous proximity levels into the clock domain.
  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      esq_p0 <= 1'b0;
      esq_p1 <= 1'b0;
      dir_p0 <= 1'b0;
      dir_p1 <= 1'b0;
    end else begin
      esq_p0 <= esq;
      esq_p1 <= esq_p0;
      dir_p0 <= dir;
      dir_p1 <= dir_p0;
    end
  end

  // ---- gesture FSM on the synchronized levels ----
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          side, side_nxt;
  logic          accept;
  logic          push_bit;

  logic only_l, only_r, none_hi;
  assign only_l  = esq_p1 & ~dir_p1;
  assign only_r  = dir_p1 & ~esq_p1;
  assign none_hi = ~esq_p1 & ~dir_p1;

  // Gesture state, debounce counter and latched side.
  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      state <= IDLE;
      cnt   <= '0;
      side  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      side  <= side_nxt;
    end
  end

  // Qualify a press, emit one accept, then insist on a qualified release.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    side_nxt  = side;
    accept    = 1'b0;
    push_bit  = side;
    if (clear_dir) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (only_l || only_r) begin
            side_nxt = only_r;
            if (DEBOUNCE_CYCLES <= 1) begin
              accept    = 1'b1;
              push_bit  = only_r;
              state_nxt = HOLD;
            end else begin
              state_nxt = QUAL;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        QUAL: begin
          if (side ? only_r : only_l) begin
            if (cnt >= CNT_LAST) begin
              accept    = 1'b1;
              push_bit  = side;
              state_nxt = HOLD;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end else if (side ? only_l : only_r) begin
            // Hand moved to the other sensor: restart qualification there.
            side_nxt = ~side;
            cnt_nxt  = CNT_ONE;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        HOLD: begin
          cnt_nxt = '0;
          if (none_hi) begin
            if (DEBOUNCE_CYCLES <= 1) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = RELQ;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        RELQ: begin
          if (!none_hi) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
          end else if (cnt >= CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // ---- turn queue and heading register ----
  logic [QDEPTH-1:0] q_data, q_data_nxt;
  logic [1:0]        q_cnt, q_cnt_nxt;
  logic [1:0]        direction_nxt;
  logic              drop_nxt;
  logic              pop;
  logic              full;

  assign pop  = apply_turn && (q_cnt != 2'd0);
  assign full = (q_cnt == Q_FULL);

  // Pop uses the current head; a same-cycle push lands behind the survivors.
  always_comb begin
    q_data_nxt    = q_data;
    q_cnt_nxt     = q_cnt;
    direction_nxt = direction;
    drop_nxt      = 1'b0;
    if (clear_dir) begin
      q_cnt_nxt     = 2'd0;
      direction_nxt = 2'd0;
    end else begin
      if (pop) begin
        direction_nxt = turn_heading(direction, q_data[0]);
        q_data_nxt    = q_data >> 1;
        q_cnt_nxt     = q_cnt - 2'd1;
      end
      if (accept) begin
        if (!full || pop) begin
          for (int i = 0; i < QDEPTH; i++) begin
            if (q_cnt_nxt == 2'(i)) begin
              q_data_nxt[i] = push_bit;
            end
          end
          q_cnt_nxt = q_cnt_nxt + 2'd1;
        end else begin
          drop_nxt = 1'b1;
        end
      end
    end
  end

  // Queue occupancy, heading and drop pulse.
  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      q_cnt        <= 2'd0;
      direction    <= 2'd0;
      turn_dropped <= 1'b0;
    end else begin
      q_cnt        <= q_cnt_nxt;
      direction    <= direction_nxt;
      turn_dropped <= drop_nxt;
    end
  end

  // Queue payload; only meaningful below q_cnt, so it carries no reset.
  always_ff @(posedge clock) begin
    q_data <= q_data_nxt;
  end

  assign turn_pending = (q_cnt != 2'd0);
  assign db_estado    = state;

endmodule

// File: tb/tb_snake_direction_ctrl.sv
// tb_snake_direction_ctrl: directed scenarios with a scoreboard; the stimulus
// pushes expected headings/drops, a monitor pops them when the DUT responds.
module tb_snake_direction_ctrl;
  localparam int D = 4;

`ifdef SNAKE_DIR_QUEUE2_EN
  localparam logic [1:0] T5_SECOND = 2'd2;
  localparam logic [1:0] T6_A      = 2'd3;
  localparam logic [1:0] T6_B      = 2'd0;
`else
  localparam logic [1:0] T5_SECOND = 2'd1;
  localparam logic [1:0] T6_A      = 2'd2;
  localparam logic [1:0] T6_B      = 2'd3;
`endif

  logic       clock      = 1'b0;
  logic       restart_n  = 1'b1;
  logic       esq        = 1'b0;
  logic       dir        = 1'b0;
  logic       clear_dir  = 1'b0;
  logic       apply_turn = 1'b0;
  logic [1:0] direction;
  logic       turn_pending;
  logic       turn_dropped;
  logic [1:0] db_estado;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_dir_q[$];
  logic       exp_drop_q[$];

  snake_direction_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clock       (clock),
    .restart_n   (restart_n),
    .esq         (esq),
    .dir         (dir),
    .clear_dir   (clear_dir),
    .apply_turn  (apply_turn),
    .direction   (direction),
    .turn_pending(turn_pending),
    .turn_dropped(turn_dropped),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic gesture(input logic right, input int hold);
    if (right) dir = 1'b1;
    else       esq = 1'b1;
    step(hold);
    esq = 1'b0;
    dir = 1'b0;
    step(10);
  endtask

  task automatic do_apply(input logic [1:0] exp);
    exp_dir_q.push_back(exp);
    apply_turn = 1'b1;
    step(1);
    apply_turn = 1'b0;
    step(2);
  endtask

  // Monitor: heading after each sampled apply, and every drop pulse.
  initial begin
    logic ap;
    forever begin
      @(posedge clock);
      ap = apply_turn;
      @(negedge clock);
      if (ap) begin
        if (exp_dir_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL apply_no_expectation: direction=%0d", direction);
        end else begin
          check("direction_after_apply", direction, exp_dir_q.pop_front());
        end
      end
      if (turn_dropped === 1'b1) begin
        if (exp_drop_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL turn_dropped_unexpected: got 1, expected 0");
        end else begin
          check("pending_at_drop", turn_pending, exp_drop_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with no clock edge yet
    #1 restart_n = 1'b0;
    #3;
    check("reset_direction", direction, 0);
    check("reset_pending", turn_pending, 0);
    check("reset_dropped", turn_dropped, 0);
    check("reset_state", db_estado, 0);
    step(2);
    restart_n = 1'b1;
    step(2);

    // 1: async reset mid-qualification with a non-zero heading and a queued turn
    gesture(1'b0, 6);
    check("pending_after_left", turn_pending, 1);
    do_apply(2'd1);
    gesture(1'b0, 6);
    check("pending_before_reset", turn_pending, 1);
    esq = 1'b1;
    step(3);
    check("state_mid_qual", db_estado, 1);
    #2 restart_n = 1'b0;
    #1;
    check("async_reset_direction", direction, 0);
    check("async_reset_pending", turn_pending, 0);
    check("async_reset_dropped", turn_dropped, 0);
    check("async_reset_state", db_estado, 0);
    esq = 1'b0;
    step(2);
    restart_n = 1'b1;
    step(2);
    gesture(1'b0, 8);
    do_apply(2'd1);

    // 2: glitch rejection from heading 0
    clear_dir = 1'b1;
    step(1);
    clear_dir = 1'b0;
    check("clear_direction", direction, 0);
    step(2);
    dir = 1'b1;
    step(3);
    dir = 1'b0;
    step(10);
    check("glitch_pending", turn_pending, 0);
    check("glitch_state", db_estado, 0);
    do_apply(2'd0);

    // 3: wrap-around
    gesture(1'b1, 6);
    do_apply(2'd3);
    gesture(1'b0, 6);
    do_apply(2'd0);
    gesture(1'b0, 6);
    do_apply(2'd1);
    gesture(1'b0, 6);
    do_apply(2'd2);
    gesture(1'b0, 6);
    do_apply(2'd3);

    // 4: long hold yields one turn; both-high yields none
    gesture(1'b0, 40);
    check("long_hold_pending", turn_pending, 1);
    do_apply(2'd0);
    check("long_hold_single", turn_pending, 0);
    do_apply(2'd0);
    esq = 1'b1;
    dir = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("both_high_state", db_estado, 0);
    end
    esq = 1'b0;
    dir = 1'b0;
    step(10);
    check("both_high_pending", turn_pending, 0);

    // 5: queue depth with two gestures and no apply
    gesture(1'b0, 6);
`ifndef SNAKE_DIR_QUEUE2_EN
    exp_drop_q.push_back(1'b1);
`endif
    gesture(1'b0, 6);
    check("depth_pending", turn_pending, 1);
    do_apply(2'd1);
    do_apply(T5_SECOND);
    check("depth_drained", turn_pending, 0);

    // 6a: accept coinciding with apply while a turn is already queued
    gesture(1'b0, 6);
    esq = 1'b1;
    step(5);
    exp_dir_q.push_back(T6_A);
    apply_turn = 1'b1;
    step(1);
    apply_turn = 1'b0;
    esq = 1'b0;
    step(10);
    check("simul_new_pending", turn_pending, 1);
    do_apply(T6_B);
    check("simul_drained", turn_pending, 0);

    // 6b: clear_dir overrides a simultaneous apply
    gesture(1'b0, 6);
    check("clear_pre_pending", turn_pending, 1);
    exp_dir_q.push_back(2'd0);
    clear_dir  = 1'b1;
    apply_turn = 1'b1;
    step(1);
    clear_dir  = 1'b0;
    apply_turn = 1'b0;
    step(2);
    check("clear_flushes_queue", turn_pending, 0);
    check("clear_state", db_estado, 0);
    do_apply(2'd0);

    step(5);
    check("dir_expectations_left", exp_dir_q.size(), 0);
    check("drop_expectations_left", exp_drop_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
